cond_mov_unit: RTL and testbench

- Parametrised, handshaked conditional-move execution unit for the multi-cycle RISC CPU.
- Captures an operation on `start`, evaluates the condition against the 2-bit compare flag, and registers the selected source into `alu_result`.
- Reports completion with a one-cycle `done` pulse, together with write-enable and illegal-opcode qualifiers.
- Supersedes the fixed 32-bit MOV unit: adds configurable widths, a sign-extended immediate path, NE/LE/GE conditions, hold-on-false semantics and a start/busy/done handshake.

---
 rtl/cond_mov_unit.sv | 115 +++++++++++
 tb/tb_cond_mov_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cond_mov_unit.sv
// Conditional-move execution unit: captures an opcode on start, evaluates its
// condition against the compare flag and registers the selected source.
module cond_mov_unit #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        flag,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_result,
  output logic              wr_en,
  output logic              illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [OP_W-1:0]           op_p0;
  logic signed [DATA_W-1:0]  reg_src_p0;
  logic signed [IMM_W-1:0]   imm_p0;
  logic [1:0]                flag_p0;
  logic [1:0]                dec_p0;
  logic signed [DATA_W-1:0]  sel_p0;
  logic signed [DATA_W-1:0]  result_p1;
  logic                      vld_p1;
  logic                      wr_p1;
  logic                      ill_p1;

  function automatic logic signed [DATA_W-1:0] sign_ext(input logic signed [IMM_W-1:0] v);
    return DATA_W'(v);
  endfunction

  // Returns {legal, taken}; opcode bits above bit 4 must all be zero.
  function automatic logic [1:0] decode(input logic [OP_W-1:0] op, input logic [1:0] f);
    logic       legal;
    logic       taken;
    logic [4:0] code;
    legal = ((op >> 5) == '0);
    taken = 1'b0;
    code  = op[4:0];
    case (code)
      5'b01110, 5'b01111: taken = 1'b1;
      5'b10000, 5'b10001: taken = (f == 2'b01);
      5'b10010, 5'b10011: taken = (f == 2'b10);
      5'b10100, 5'b10101: taken = (f == 2'b11);
      5'b10110, 5'b10111: taken = (f != 2'b01);
      5'b11000, 5'b11001: taken = (f == 2'b01) || (f == 2'b10);
      5'b11010, 5'b11011: taken = (f == 2'b01) || (f == 2'b11);
      default:            legal = 1'b0;
    endcase
    return {legal, legal & taken};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dec_p0 = decode(op_p0, flag_p0);
  assign sel_p0 = op_p0[0] ? sign_ext(imm_p0) : reg_src_p0;

  // Stage p0: operand capture on accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      op_p0      <= '0;
      reg_src_p0 <= '0;
      imm_p0     <= '0;
      flag_p0    <= '0;
    end else if (state == S_IDLE && start) begin
      op_p0      <= alu_control;
      reg_src_p0 <= alu_in;
      imm_p0     <= imm_in;
      flag_p0    <= flag;
    end
  end

  // Stage p1: evaluate and register result plus one-cycle qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
      wr_p1     <= 1'b0;
      ill_p1    <= 1'b0;
    end else begin
      vld_p1 <= (state == S_EXEC);
      wr_p1  <= (state == S_EXEC) && dec_p0[0];
      ill_p1 <= (state == S_EXEC) && !dec_p0[1];
      if (state == S_EXEC && dec_p0[0]) result_p1 <= sel_p0;
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = vld_p1;
  assign wr_en      = wr_p1;
  assign illegal    = ill_p1;
  assign alu_result = result_p1;

endmodule

// File: tb/tb_cond_mov_unit.sv
// Directed bench for cond_mov_unit: vector table plus handshake/reset sequences.
module tb_cond_mov_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alu_control;
  logic [31:0] alu_in;
  logic [15:0] imm_in;
  logic [1:0]  flag;
  logic        busy, done, wr_en, illegal;
  logic [31:0] alu_result;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [15:0] imm;
    logic [1:0]  flag;
    logic [31:0] exp_res;
    logic        exp_wr;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  cond_mov_unit #(.DATA_W(32), .IMM_W(16), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
    .alu_in(alu_in), .imm_in(imm_in), .flag(flag), .busy(busy), .done(done),
    .alu_result(alu_result), .wr_en(wr_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [15:0] imm, input logic [1:0] f,
                         input logic [31:0] res, input logic wr, input logic ill);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.imm = imm; v.flag = f;
    v.exp_res = res; v.exp_wr = wr; v.exp_ill = ill;
    vecs.push_back(v);
  endtask

  // Start at edge T, scramble inputs after capture, check T, T+1, T+2.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    alu_control = v.op; alu_in = v.a; imm_in = v.imm; flag = v.flag; start = 1'b1;
    @(posedge clk); #1;
    chk({v.name, " busy@T"}, 32'(busy), 32'd1);
    chk({v.name, " done@T"}, 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0; alu_control = 5'b01110; alu_in = ~v.a; imm_in = ~v.imm; flag = ~v.flag;
    @(posedge clk); #1;
    chk({v.name, " done"},    32'(done),    32'd1);
    chk({v.name, " wr_en"},   32'(wr_en),   32'(v.exp_wr));
    chk({v.name, " illegal"}, 32'(illegal), 32'(v.exp_ill));
    chk({v.name, " result"},  alu_result,   v.exp_res);
    chk({v.name, " busy@T1"}, 32'(busy),    32'd1);
    @(posedge clk); #1;
    chk({v.name, " done@T2"}, 32'({done, wr_en, illegal, busy}), 32'd0);
    chk({v.name, " hold@T2"}, alu_result, v.exp_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_control = '0; alu_in = '0; imm_in = '0; flag = '0;

    add_vec("MOV42",      5'b01110, 32'd42,     16'h0,    2'b00, 32'd42,        1'b1, 1'b0);
    add_vec("MOVEQ_nt",   5'b10000, 32'd88,     16'h0,    2'b00, 32'd42,        1'b0, 1'b0);
    add_vec("MOVEQ_t",    5'b10000, 32'd55,     16'h0,    2'b01, 32'd55,        1'b1, 1'b0);
    add_vec("MOVI_neg",   5'b01111, 32'd0,      16'hFFF6, 2'b00, 32'hFFFFFFF6,  1'b1, 1'b0);
    add_vec("MOVIG_t",    5'b10101, 32'd0,      16'h0309, 2'b11, 32'd777,       1'b1, 1'b0);
    add_vec("MOVNE_t",    5'b10110, 32'd7,      16'h0,    2'b10, 32'd7,         1'b1, 1'b0);
    add_vec("MOV1a",      5'b01110, 32'd1,      16'h0,    2'b00, 32'd1,         1'b1, 1'b0);
    add_vec("MOVLE_nt",   5'b11000, 32'd7,      16'h0,    2'b11, 32'd1,         1'b0, 1'b0);
    add_vec("MOVGE_t",    5'b11010, 32'd7,      16'h0,    2'b01, 32'd7,         1'b1, 1'b0);
    add_vec("MOV1b",      5'b01110, 32'd1,      16'h0,    2'b00, 32'd1,         1'b1, 1'b0);
    add_vec("MOVGE_nt",   5'b11010, 32'd7,      16'h0,    2'b10, 32'd1,         1'b0, 1'b0);
    add_vec("ILL00011",   5'b00011, 32'd99,     16'h0,    2'b01, 32'd1,         1'b0, 1'b1);
    add_vec("MOVIL_t",    5'b10011, 32'd0,      16'h0005, 2'b10, 32'd5,         1'b1, 1'b0);
    add_vec("MOVILE_t",   5'b11001, 32'd0,      16'h8000, 2'b01, 32'hFFFF8000,  1'b1, 1'b0);
    add_vec("MOVINE_nt",  5'b10111, 32'd0,      16'h0010, 2'b01, 32'hFFFF8000,  1'b0, 1'b0);
    add_vec("MOVIGE_t",   5'b11011, 32'd0,      16'h7FFF, 2'b11, 32'h00007FFF,  1'b1, 1'b0);
    add_vec("MOVG_nt",    5'b10100, 32'hDEAD,   16'h0,    2'b10, 32'h00007FFF,  1'b0, 1'b0);
    add_vec("ILL11100",   5'b11100, 32'd3,      16'h0,    2'b00, 32'h00007FFF,  1'b0, 1'b1);
    add_vec("MOVL_t",     5'b10010, 32'h1234,   16'h0,    2'b10, 32'h1234,      1'b1, 1'b0);
    add_vec("MOVIEQ_nt",  5'b10001, 32'd0,      16'h0001, 2'b00, 32'h1234,      1'b0, 1'b0);
    add_vec("ILL00000",   5'b00000, 32'd0,      16'h0,    2'b00, 32'h1234,      1'b0, 1'b1);
    add_vec("MOVNE_none", 5'b10110, 32'hCAFE,   16'h0,    2'b00, 32'hCAFE,      1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'({busy, done, wr_en, illegal}), 32'd0);
    chk("reset result",  alu_result, 32'd0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Start pulses while busy must be ignored.
    @(negedge clk);
    alu_control = 5'b01110; alu_in = 32'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk); alu_in = 32'd99;
    @(posedge clk); #1;
    chk("busy-ign done", 32'(done), 32'd1);
    chk("busy-ign result", alu_result, 32'd10);
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy-ign no 2nd done", 32'({done, busy}), 32'd0);
    chk("busy-ign final", alu_result, 32'd10);

    // Held start: operations every 3 cycles.
    @(negedge clk);
    alu_control = 5'b01110; alu_in = 32'd20; start = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("b2b done1", 32'(done), 32'd1);
    chk("b2b res1", alu_result, 32'd20);
    @(negedge clk); alu_in = 32'd30;
    @(posedge clk); #1;
    chk("b2b gap", 32'({done, busy}), 32'd0);
    @(posedge clk); #1;
    chk("b2b busy2", 32'({done, busy}), 32'd1);
    @(posedge clk); #1;
    chk("b2b done2", 32'(done), 32'd1);
    chk("b2b res2", alu_result, 32'd30);
    @(negedge clk); start = 1'b0;
    @(posedge clk);

    // Reset mid-operation: no done pulse, result cleared.
    @(negedge clk);
    alu_control = 5'b01110; alu_in = 32'd123; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst outputs", 32'({busy, done, wr_en, illegal}), 32'd0);
    chk("midrst result", alu_result, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst no done", 32'({busy, done}), 32'd0);
    begin
      vec_t v;
      v.name = "MOV5"; v.op = 5'b01110; v.a = 32'd5; v.imm = 16'h0; v.flag = 2'b00;
      v.exp_res = 32'd5; v.exp_wr = 1'b1; v.exp_ill = 1'b0;
      run_op(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
